// File: rtl/fxu_rs.sv
// fxu_rs: reservation-station bank in front of the FXU (ADD/JEQ unit).
// Holds renamed instructions until both operands are present. Operands come
// from the issue port or are picked up by snooping the CDB. Ready entries are
// sent to the FXU one at a time. Each entry's tag doubles as its result tag,
// so an entry stays allocated until its own result is broadcast.
module fxu_rs #(
    parameter int         NRS     = 4,
    parameter logic [5:0] RS_BASE = 6'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        issue_valid,
    input  logic [3:0]  issue_op,
    input  logic        issue_rdy0,
    input  logic [15:0] issue_val0,
    input  logic [5:0]  issue_tag0,
    input  logic        issue_rdy1,
    input  logic [15:0] issue_val1,
    input  logic [5:0]  issue_tag1,
    output logic        full,
    output logic [5:0]  issue_tag,
    input  logic        cdb_valid,
    input  logic [5:0]  cdb_tag,
    input  logic [15:0] cdb_val,
    input  logic        fxu_busy,
    output logic        fxu_valid,
    output logic [5:0]  fxu_rs_num,
    output logic [3:0]  fxu_op,
    output logic [15:0] fxu_val0,
    output logic [15:0] fxu_val1
);

    localparam int IW = (NRS > 1) ? $clog2(NRS) : 1;

    localparam logic [1:0] ST_FREE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_READY  = 2'd2;
    localparam logic [1:0] ST_ISSUED = 2'd3;

    logic [1:0]  state  [NRS];
    logic [3:0]  op_q   [NRS];
    logic        rdy0_q [NRS];
    logic        rdy1_q [NRS];
    logic [15:0] val0_q [NRS];
    logic [15:0] val1_q [NRS];
    logic [5:0]  tag0_q [NRS];
    logic [5:0]  tag1_q [NRS];

    logic [NRS-1:0] free_vec;
    logic [NRS-1:0] ready_vec;
    logic [NRS-1:0] hit0;
    logic [NRS-1:0] hit1;
    logic [IW-1:0]  alloc_idx;
    logic [IW-1:0]  disp_idx;

    logic        in_rdy0;
    logic        in_rdy1;
    logic [15:0] in_val0;
    logic [15:0] in_val1;
    logic        do_issue;
    logic        do_disp;

    // Tag owned by entry idx; also the tag its FXU result carries on the CDB.
    function automatic logic [5:0] entry_tag(input int idx);
        return RS_BASE + 6'(idx);
    endfunction

    // Per-entry status vectors, CDB snoop hits and lowest-index pickers for allocation and dispatch.
    always_comb begin
        free_vec  = '0;
        ready_vec = '0;
        hit0      = '0;
        hit1      = '0;
        alloc_idx = '0;
        disp_idx  = '0;
        for (int i = 0; i < NRS; i++) begin
            free_vec[i]  = (state[i] == ST_FREE);
            ready_vec[i] = (state[i] == ST_READY);
            hit0[i] = cdb_valid && (state[i] == ST_WAIT) && !rdy0_q[i] && (tag0_q[i] == cdb_tag);
            hit1[i] = cdb_valid && (state[i] == ST_WAIT) && !rdy1_q[i] && (tag1_q[i] == cdb_tag);
        end
        for (int i = NRS - 1; i >= 0; i--) begin
            if (free_vec[i]) begin
                alloc_idx = IW'(i);
            end
            if (ready_vec[i]) begin
                disp_idx = IW'(i);
            end
        end
    end

    // Issue-side operand resolution, including the same-cycle CDB bypass.
    always_comb begin
        in_rdy0   = issue_rdy0 || (cdb_valid && (cdb_tag == issue_tag0));
        in_rdy1   = issue_rdy1 || (cdb_valid && (cdb_tag == issue_tag1));
        in_val0   = issue_rdy0 ? issue_val0 : cdb_val;
        in_val1   = issue_rdy1 ? issue_val1 : cdb_val;
        full      = ~|free_vec;
        issue_tag = RS_BASE + 6'(alloc_idx);
        do_issue  = issue_valid && !full;
        do_disp   = !fxu_valid && !fxu_busy && (|ready_vec);
    end

    // Entry state machines: allocate on issue, capture CDB operands, mark dispatch, free on own result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NRS; i++) begin
                state[i]  <= ST_FREE;
                op_q[i]   <= '0;
                rdy0_q[i] <= 1'b0;
                rdy1_q[i] <= 1'b0;
                val0_q[i] <= '0;
                val1_q[i] <= '0;
                tag0_q[i] <= '0;
                tag1_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NRS; i++) begin
                case (state[i])
                    ST_FREE: begin
                        if (do_issue && (alloc_idx == IW'(i))) begin
                            op_q[i]   <= issue_op;
                            rdy0_q[i] <= in_rdy0;
                            rdy1_q[i] <= in_rdy1;
                            val0_q[i] <= in_val0;
                            val1_q[i] <= in_val1;
                            tag0_q[i] <= issue_tag0;
                            tag1_q[i] <= issue_tag1;
                            state[i]  <= (in_rdy0 && in_rdy1) ? ST_READY : ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (hit0[i]) begin
                            val0_q[i] <= cdb_val;
                            rdy0_q[i] <= 1'b1;
                        end
                        if (hit1[i]) begin
                            val1_q[i] <= cdb_val;
                            rdy1_q[i] <= 1'b1;
                        end
                        if ((rdy0_q[i] || hit0[i]) && (rdy1_q[i] || hit1[i])) begin
                            state[i] <= ST_READY;
                        end
                    end
                    ST_READY: begin
                        if (do_disp && (disp_idx == IW'(i))) begin
                            state[i] <= ST_ISSUED;
                        end
                    end
                    default: begin
                        if (cdb_valid && (cdb_tag == entry_tag(i))) begin
                            state[i] <= ST_FREE;
                        end
                    end
                endcase
            end
        end
    end

    // Dispatch register: one-cycle strobe, payload held until the next dispatch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fxu_valid  <= 1'b0;
            fxu_rs_num <= '0;
            fxu_op     <= '0;
            fxu_val0   <= '0;
            fxu_val1   <= '0;
        end else if (fxu_valid) begin
            fxu_valid <= 1'b0;
        end else if (do_disp) begin
            fxu_valid  <= 1'b1;
            fxu_rs_num <= RS_BASE + 6'(disp_idx);
            fxu_op     <= op_q[disp_idx];
            fxu_val0   <= val0_q[disp_idx];
            fxu_val1   <= val1_q[disp_idx];
        end
    end

endmodule

// File: tb/tb_fxu_rs.sv
// tb_fxu_rs: directed testbench for the FXU reservation-station bank.
module tb_fxu_rs;

    logic        clk;
    logic        rst_n;
    logic        issue_valid;
    logic [3:0]  issue_op;
    logic        issue_rdy0;
    logic [15:0] issue_val0;
    logic [5:0]  issue_tag0;
    logic        issue_rdy1;
    logic [15:0] issue_val1;
    logic [5:0]  issue_tag1;
    logic        full;
    logic [5:0]  issue_tag;
    logic        cdb_valid;
    logic [5:0]  cdb_tag;
    logic [15:0] cdb_val;
    logic        fxu_busy;
    logic        fxu_valid;
    logic [5:0]  fxu_rs_num;
    logic [3:0]  fxu_op;
    logic [15:0] fxu_val0;
    logic [15:0] fxu_val1;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    fxu_rs #(.NRS(4), .RS_BASE(6'd0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .issue_valid(issue_valid),
        .issue_op   (issue_op),
        .issue_rdy0 (issue_rdy0),
        .issue_val0 (issue_val0),
        .issue_tag0 (issue_tag0),
        .issue_rdy1 (issue_rdy1),
        .issue_val1 (issue_val1),
        .issue_tag1 (issue_tag1),
        .full       (full),
        .issue_tag  (issue_tag),
        .cdb_valid  (cdb_valid),
        .cdb_tag    (cdb_tag),
        .cdb_val    (cdb_val),
        .fxu_busy   (fxu_busy),
        .fxu_valid  (fxu_valid),
        .fxu_rs_num (fxu_rs_num),
        .fxu_op     (fxu_op),
        .fxu_val0   (fxu_val0),
        .fxu_val1   (fxu_val1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just past the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic set_issue(input logic [3:0] op,
                             input logic r0, input logic [15:0] v0, input logic [5:0] t0,
                             input logic r1, input logic [15:0] v1, input logic [5:0] t1);
        issue_valid = 1'b1;
        issue_op    = op;
        issue_rdy0  = r0;
        issue_val0  = v0;
        issue_tag0  = t0;
        issue_rdy1  = r1;
        issue_val1  = v1;
        issue_tag1  = t1;
    endtask

    // Broadcast one result on the CDB for a single cycle.
    task automatic broadcast(input logic [5:0] t, input logic [15:0] v);
        cdb_valid = 1'b1;
        cdb_tag   = t;
        cdb_val   = v;
        step();
        cdb_valid = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (fxu_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %0b want 0", fxu_valid); end
        checks++;
        if (full !== 1'b0 || issue_tag !== 6'd0) begin
            errors++; $display("[TB] FAIL reset_alloc got full=%0b tag=%0d want full=0 tag=0", full, issue_tag);
        end
        checks++;
        if (fxu_rs_num !== 6'd0 || fxu_op !== 4'd0 || fxu_val0 !== 16'd0 || fxu_val1 !== 16'd0) begin
            errors++; $display("[TB] FAIL reset_payload got %0d/%0d/%0h/%0h want zeros", fxu_rs_num, fxu_op, fxu_val0, fxu_val1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic_add();
        set_issue(4'd1, 1'b1, 16'd5, 6'd0, 1'b1, 16'd7, 6'd0);
        checks++;
        if (issue_tag !== 6'd0) begin errors++; $display("[TB] FAIL add_issue_tag got %0d want 0", issue_tag); end
        step();
        issue_valid = 1'b0;
        checks++;
        if (fxu_valid !== 1'b0) begin errors++; $display("[TB] FAIL add_no_same_cycle got %0b want 0", fxu_valid); end
        step();
        checks++;
        if (fxu_valid !== 1'b1 || fxu_rs_num !== 6'd0 || fxu_op !== 4'd1 || fxu_val0 !== 16'd5 || fxu_val1 !== 16'd7) begin
            errors++; $display("[TB] FAIL add_dispatch got v=%0b rs=%0d op=%0d %0d %0d want 1 0 1 5 7",
                               fxu_valid, fxu_rs_num, fxu_op, fxu_val0, fxu_val1);
        end
        step();
        checks++;
        if (fxu_valid !== 1'b0 || fxu_rs_num !== 6'd0 || fxu_val1 !== 16'd7) begin
            errors++; $display("[TB] FAIL add_pulse_hold got v=%0b rs=%0d val1=%0d want 0 0 7", fxu_valid, fxu_rs_num, fxu_val1);
        end
        checks++;
        if (issue_tag !== 6'd1) begin errors++; $display("[TB] FAIL add_still_held got %0d want 1", issue_tag); end
        broadcast(6'd0, 16'd12);
        checks++;
        if (issue_tag !== 6'd0 || full !== 1'b0) begin
            errors++; $display("[TB] FAIL add_reuse got tag=%0d full=%0b want 0 0", issue_tag, full);
        end
    endtask

    task automatic test_jeq_wait();
        logic seen;
        set_issue(4'd6, 1'b0, 16'd0, 6'd9, 1'b1, 16'd3, 6'd0);
        checks++;
        if (issue_tag !== 6'd0) begin errors++; $display("[TB] FAIL jeq_issue_tag got %0d want 0", issue_tag); end
        step();
        issue_valid = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            seen = seen | fxu_valid;
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("[TB] FAIL jeq_waits got %0b want 0", seen); end
        broadcast(6'd9, 16'd3);
        checks++;
        if (fxu_valid !== 1'b0) begin errors++; $display("[TB] FAIL jeq_ready_delay got %0b want 0", fxu_valid); end
        step();
        checks++;
        if (fxu_valid !== 1'b1 || fxu_op !== 4'd6 || fxu_val0 !== 16'd3 || fxu_val1 !== 16'd3 || fxu_rs_num !== 6'd0) begin
            errors++; $display("[TB] FAIL jeq_dispatch got v=%0b rs=%0d op=%0d %0d %0d want 1 0 6 3 3",
                               fxu_valid, fxu_rs_num, fxu_op, fxu_val0, fxu_val1);
        end
        step();
        broadcast(6'd0, 16'd0);
    endtask

    task automatic test_bypass();
        set_issue(4'd1, 1'b0, 16'd0, 6'd12, 1'b1, 16'h0055, 6'd0);
        cdb_valid = 1'b1;
        cdb_tag   = 6'd12;
        cdb_val   = 16'h00AA;
        step();
        issue_valid = 1'b0;
        cdb_valid   = 1'b0;
        step();
        checks++;
        if (fxu_valid !== 1'b1 || fxu_val0 !== 16'h00AA || fxu_val1 !== 16'h0055) begin
            errors++; $display("[TB] FAIL bypass got v=%0b val0=%0h val1=%0h want 1 aa 55", fxu_valid, fxu_val0, fxu_val1);
        end
        step();
        broadcast(6'd0, 16'd0);
    endtask

    task automatic test_fill_and_order();
        int n;
        int last;
        for (int k = 0; k < 4; k++) begin
            set_issue(4'd1, 1'b0, 16'd0, 6'd20, 1'b0, 16'd0, 6'd20);
            checks++;
            if (issue_tag !== 6'(k) || full !== 1'b0) begin
                errors++; $display("[TB] FAIL fill_tag_%0d got tag=%0d full=%0b want %0d 0", k, issue_tag, full, k);
            end
            step();
        end
        set_issue(4'd6, 1'b1, 16'd9, 6'd0, 1'b1, 16'd9, 6'd0);
        checks++;
        if (full !== 1'b1) begin errors++; $display("[TB] FAIL fill_full got %0b want 1", full); end
        step();
        issue_valid = 1'b0;
        broadcast(6'd20, 16'd1);
        last = 0;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            do begin
                step();
                n++;
            end while (!fxu_valid && n < 12);
            checks++;
            if (fxu_valid !== 1'b1 || fxu_rs_num !== 6'(k) || fxu_op !== 4'd1 || fxu_val0 !== 16'd1 || fxu_val1 !== 16'd1) begin
                errors++; $display("[TB] FAIL order_%0d got v=%0b rs=%0d op=%0d %0d %0d want 1 %0d 1 1 1",
                                   k, fxu_valid, fxu_rs_num, fxu_op, fxu_val0, fxu_val1, k);
            end
            if (k > 0) begin
                checks++;
                if (cycle - last !== 3) begin errors++; $display("[TB] FAIL spacing_%0d got %0d want 3", k, cycle - last); end
            end
            last = cycle;
            fxu_busy = 1'b1;
            step();
            step();
            fxu_busy = 1'b0;
        end
        step();
        checks++;
        if (fxu_valid !== 1'b0 || full !== 1'b1) begin
            errors++; $display("[TB] FAIL fill_held got v=%0b full=%0b want 0 1", fxu_valid, full);
        end
        broadcast(6'd0, 16'd0);
        checks++;
        if (full !== 1'b0 || issue_tag !== 6'd0) begin
            errors++; $display("[TB] FAIL fill_free got full=%0b tag=%0d want 0 0", full, issue_tag);
        end
        broadcast(6'd1, 16'd0);
        broadcast(6'd2, 16'd0);
        broadcast(6'd3, 16'd0);
    endtask

    task automatic test_busy_hold();
        logic seen;
        fxu_busy = 1'b1;
        set_issue(4'd1, 1'b1, 16'h0011, 6'd0, 1'b1, 16'h0022, 6'd0);
        step();
        set_issue(4'd6, 1'b1, 16'h0033, 6'd0, 1'b1, 16'h0044, 6'd0);
        step();
        issue_valid = 1'b0;
        broadcast(6'd0, 16'hFFFF);
        seen = fxu_valid;
        for (int k = 0; k < 3; k++) begin
            step();
            seen = seen | fxu_valid;
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("[TB] FAIL busy_blocks got %0b want 0", seen); end
        checks++;
        if (issue_tag !== 6'd2) begin errors++; $display("[TB] FAIL ready_ignores_cdb got %0d want 2", issue_tag); end
        fxu_busy = 1'b0;
        step();
        checks++;
        if (fxu_valid !== 1'b1 || fxu_rs_num !== 6'd0 || fxu_val0 !== 16'h0011 || fxu_val1 !== 16'h0022) begin
            errors++; $display("[TB] FAIL busy_first got v=%0b rs=%0d %0h %0h want 1 0 11 22", fxu_valid, fxu_rs_num, fxu_val0, fxu_val1);
        end
        step();
        step();
        checks++;
        if (fxu_valid !== 1'b1 || fxu_rs_num !== 6'd1 || fxu_op !== 4'd6 || fxu_val0 !== 16'h0033) begin
            errors++; $display("[TB] FAIL busy_second got v=%0b rs=%0d op=%0d %0h want 1 1 6 33", fxu_valid, fxu_rs_num, fxu_op, fxu_val0);
        end
        step();
        broadcast(6'd0, 16'd0);
        broadcast(6'd1, 16'd0);
    endtask

    task automatic test_reset_mid();
        set_issue(4'd1, 1'b1, 16'd4, 6'd0, 1'b1, 16'd8, 6'd0);
        step();
        set_issue(4'd1, 1'b0, 16'd0, 6'd30, 1'b1, 16'd2, 6'd0);
        step();
        issue_valid = 1'b0;
        checks++;
        if (fxu_valid !== 1'b1 || issue_tag !== 6'd2) begin
            errors++; $display("[TB] FAIL mid_setup got v=%0b tag=%0d want 1 2", fxu_valid, issue_tag);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (fxu_valid !== 1'b0 || full !== 1'b0 || issue_tag !== 6'd0 || fxu_rs_num !== 6'd0) begin
            errors++; $display("[TB] FAIL mid_reset got v=%0b full=%0b tag=%0d rs=%0d want 0 0 0 0",
                               fxu_valid, full, issue_tag, fxu_rs_num);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        step();
        checks++;
        if (fxu_valid !== 1'b0 || issue_tag !== 6'd0) begin
            errors++; $display("[TB] FAIL post_reset got v=%0b tag=%0d want 0 0", fxu_valid, issue_tag);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        issue_valid = 1'b0;
        issue_op    = '0;
        issue_rdy0  = 1'b0;
        issue_val0  = '0;
        issue_tag0  = '0;
        issue_rdy1  = 1'b0;
        issue_val1  = '0;
        issue_tag1  = '0;
        cdb_valid   = 1'b0;
        cdb_tag     = '0;
        cdb_val     = '0;
        fxu_busy    = 1'b0;

        test_reset();
        test_basic_add();
        test_jeq_wait();
        test_bypass();
        test_fill_and_order();
        test_busy_hold();
        test_reset_mid();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
